// File: rtl/cdb_arbiter_if.sv
// ==========================================================================
// cdb_arbiter_if : requester/broadcast bundle for the common-data-bus arbiter
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface cdb_arbiter_if #(
  parameter int NREQ = 6,
  parameter int TAGW = 3,
  parameter int DW   = 32,
  parameter int SRCW = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ*DW-1:0]   req_data;
  logic                 cdb_ready;
  logic                 flush;
  logic [NREQ-1:0]      grant;
  logic                 cdb_valid;
  logic [TAGW-1:0]      cdb_tag;
  logic [DW-1:0]        cdb_data;
  logic [SRCW-1:0]      cdb_src;
  logic [15:0]          bcast_cnt;

  modport master (
    output req, req_tag, req_data, cdb_ready, flush,
    input  grant, cdb_valid, cdb_tag, cdb_data, cdb_src, bcast_cnt
  );

  modport slave (
    input  req, req_tag, req_data, cdb_ready, flush,
    output grant, cdb_valid, cdb_tag, cdb_data, cdb_src, bcast_cnt
  );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ==========================================================================
// cdb_arbiter : round-robin grant of one completing result per cycle onto the CDB
// Revision: 1.0
// ==========================================================================
`default_nettype none

module cdb_arbiter #(
  parameter int NREQ = 6,
  parameter int TAGW = 3,
  parameter int DW   = 32,
  parameter int SRCW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  cdb_arbiter_if.slave bus
);

  localparam logic [SRCW:0]   C_NREQ_W = (SRCW+1)'(NREQ);
  localparam logic [SRCW-1:0] C_LAST   = SRCW'(NREQ-1);

  logic [TAGW-1:0] req_tag_w  [NREQ];
  logic [DW-1:0]   req_data_w [NREQ];

  logic [SRCW-1:0] ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            valid_q;
  logic [TAGW-1:0] tag_q;
  logic [DW-1:0]   data_q;
  logic [SRCW-1:0] src_q;

  logic            found_w;
  logic [SRCW-1:0] win_w;
  logic [SRCW:0]   sum_w;
  logic [NREQ-1:0] grant_w;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_tag_w[i]  = bus.req_tag[i*TAGW +: TAGW];
    assign req_data_w[i] = bus.req_data[i*DW +: DW];
  end

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    found_w = 1'b0;
    win_w   = '0;
    sum_w   = '0;
    grant_w = '0;
    if (rst_n && bus.cdb_ready && !bus.flush) begin
      for (int k = 0; k < NREQ; k++) begin
        sum_w = {1'b0, ptr_q} + (SRCW+1)'(k);
        if (sum_w >= C_NREQ_W) begin
          sum_w = sum_w - C_NREQ_W;
        end
        if (!found_w && bus.req[sum_w[SRCW-1:0]]) begin
          found_w = 1'b1;
          win_w   = sum_w[SRCW-1:0];
        end
      end
    end
    if (found_w) begin
      grant_w[win_w] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (found_w) begin
      ptr_d = (win_w == C_LAST) ? '0 : win_w + SRCW'(1);
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= found_w;
      if (found_w) begin
        tag_q  <= req_tag_w[win_w];
        data_q <= req_data_w[win_w];
        src_q  <= win_w;
      end
    end
  end

  assign bus.grant     = grant_w;
  assign bus.cdb_valid = valid_q;
  assign bus.cdb_tag   = tag_q;
  assign bus.cdb_data  = data_q;
  assign bus.cdb_src   = src_q;
  assign bus.bcast_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ==========================================================================
// tb_cdb_arbiter : scoreboard bench with a round-robin reference model
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_cdb_arbiter;

  localparam int NREQ = 6;
  localparam int TAGW = 3;
  localparam int DW   = 32;
  localparam int SRCW = 3;

  typedef struct {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   data;
    logic [SRCW-1:0] src;
    logic [15:0]     cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  exp_t            exp_q[$];
  logic [TAGW-1:0] tag_a  [NREQ];
  logic [DW-1:0]   data_a [NREQ];

  int              m_ptr;
  int              m_cnt;
  exp_t            m_out;

  cdb_arbiter_if #(.NREQ(NREQ), .TAGW(TAGW), .DW(DW), .SRCW(SRCW)) bus ();

  cdb_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .DW(DW), .SRCW(SRCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, predict grant and the next broadcast state.
  task automatic cycle(input logic [NREQ-1:0] r, input logic rdy, input logic fl, input logic rn);
    int g;
    int i;
    logic [NREQ-1:0] exp_grant;
    @(posedge clk);
    #2;
    rst_n         = rn;
    bus.req       = r;
    bus.cdb_ready = rdy;
    bus.flush     = fl;
    for (int n = 0; n < NREQ; n++) begin
      bus.req_tag[n*TAGW +: TAGW] = tag_a[n];
      bus.req_data[n*DW +: DW]    = data_a[n];
    end
    @(negedge clk);
    g = -1;
    if (rn && rdy && !fl) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (g < 0 && r[i]) g = i;
      end
    end
    exp_grant = '0;
    if (g >= 0) exp_grant[g] = 1'b1;
    chk("grant", 64'(bus.grant), 64'(exp_grant));
    if (!rn) begin
      m_out.valid = 1'b0;
      m_out.tag   = '0;
      m_out.data  = '0;
      m_out.src   = '0;
      m_ptr       = 0;
      m_cnt       = 0;
    end else if (g >= 0) begin
      m_out.valid = 1'b1;
      m_out.tag   = tag_a[g];
      m_out.data  = data_a[g];
      m_out.src   = SRCW'(g);
      m_ptr       = (g + 1) % NREQ;
      m_cnt       = (m_cnt + 1) % 65536;
    end else begin
      m_out.valid = 1'b0;
    end
    m_out.cnt = 16'(m_cnt);
    exp_q.push_back(m_out);
  endtask

  // Monitor: registered outputs settle after each edge; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(e.valid));
        chk("bcast_cnt", 64'(bus.bcast_cnt), 64'(e.cnt));
        if (e.valid || !rst_n) begin
          chk("cdb_tag",  64'(bus.cdb_tag),  64'(e.tag));
          chk("cdb_data", 64'(bus.cdb_data), 64'(e.data));
          chk("cdb_src",  64'(bus.cdb_src),  64'(e.src));
        end
      end
    end
  end

  initial begin
    m_ptr = 0;
    m_cnt = 0;
    m_out = '{valid: 1'b0, tag: '0, data: '0, src: '0, cnt: '0};
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    bus.cdb_ready = 1'b0;
    bus.flush     = 1'b0;
    for (int n = 0; n < NREQ; n++) begin
      tag_a[n]  = TAGW'(n);
      data_a[n] = 32'hA000_0000 + n;
    end

    // Reset, then idle with outputs at zero.
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle(6'b111111, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) cycle('0, 1'b1, 1'b0, 1'b1);

    // Single request from requester 1, then show the pointer advanced to 2.
    tag_a[1]  = 3'd5;
    data_a[1] = 32'h1234;
    cycle(6'b000010, 1'b1, 1'b0, 1'b1);
    cycle(6'b000110, 1'b1, 1'b0, 1'b1);
    cycle('0, 1'b1, 1'b0, 1'b1);

    // All six requesting continuously from reset: 0..5 then wrap to 0.
    cycle('0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) cycle(6'b111111, 1'b1, 1'b0, 1'b1);
    cycle('0, 1'b1, 1'b0, 1'b1);

    // Hold-off on busy ROB with the pointer at 3.
    cycle('0, 1'b1, 1'b0, 1'b0);
    cycle(6'b000100, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) cycle(6'b010010, 1'b0, 1'b0, 1'b1);
    cycle(6'b010010, 1'b1, 1'b0, 1'b1);
    cycle(6'b000010, 1'b1, 1'b0, 1'b1);
    cycle('0, 1'b1, 1'b0, 1'b1);

    // Flush blocks requester 2, which is granted once flush drops.
    cycle(6'b000100, 1'b1, 1'b1, 1'b1);
    cycle(6'b000100, 1'b1, 1'b0, 1'b1);
    cycle('0, 1'b1, 1'b0, 1'b1);

    // Randomized traffic with occasional stalls, flushes and resets.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < NREQ; n++) begin
        tag_a[n]  = TAGW'($urandom);
        data_a[n] = $urandom;
      end
      cycle(NREQ'($urandom), ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 64) != 0);
    end

    // Counter wrap, then reset in a cycle that would have granted.
    while (m_cnt != 65535) cycle(6'b111111, 1'b1, 1'b0, 1'b1);
    cycle(6'b001000, 1'b1, 1'b0, 1'b1);
    cycle(6'b100001, 1'b1, 1'b0, 1'b1);
    cycle(6'b111111, 1'b1, 1'b0, 1'b0);
    cycle(6'b000100, 1'b1, 1'b0, 1'b1);
    cycle('0, 1'b1, 1'b0, 1'b1);
    cycle('0, 1'b1, 1'b0, 1'b1);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the Tomasulo back end. It sits between the completing execution resources and the single result broadcast bus: the load/store unit and the reservation stations ADD1–ADD3 and MUL1–MUL2. It grants at most one requester per cycle using round-robin priority. The granted result is registered and broadcast as ROB tag, value and source ID to the reorder buffer and every reservation station.

## Interface
Parameters:
- NREQ, 6: number of requesters; index 0 = LS, 1 = ADD1, 2 = ADD2, 3 = ADD3, 4 = MUL1, 5 = MUL2.
- TAGW, 3: ROB tag width (8 ROB entries).
- DW, 32: result data width.
- SRCW, 3: source-ID width, equal to ceil(log2(NREQ)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  NREQ  result-ready request; bit i belongs to requester i.
- req_tag  input  NREQ*TAGW  ROB tag for each requester; slice i is bits [i*TAGW +: TAGW].
- req_data  input  NREQ*DW  result value for each requester; slice i is bits [i*DW +: DW].
- cdb_ready  input  1  the ROB can accept a write this cycle.
- flush  input  1  mispredict/exception flush.
- grant  output  NREQ  combinational one-hot grant; all zeros when no grant.
- cdb_valid  output  1  broadcast valid (registered).
- cdb_tag  output  TAGW  broadcast ROB tag (registered).
- cdb_data  output  DW  broadcast value (registered).
- cdb_src  output  SRCW  index of the granted requester (registered).
- bcast_cnt  output  16  total broadcasts since reset; wraps at 65535 -> 0.

## Operation
- Internal state: round-robin pointer ptr (SRCW bits, range 0..NREQ-1), plus the output registers.
- Arbitration is enabled when cdb_ready=1 and flush=0.
  - When enabled, scan requesters ptr, ptr+1, …, NREQ-1, 0, …, ptr-1. The first with req=1 is the winner g.
  - grant[g]=1; all other grant bits are 0.
- When arbitration is disabled, or no req bit is set, grant is all zeros.
- Clock edge with a grant:
  - cdb_valid<=1, cdb_tag<=req_tag slice g, cdb_data<=req_data slice g, cdb_src<=g.
  - ptr<=(g+1) mod NREQ; g=NREQ-1 wraps to 0.
  - bcast_cnt<=bcast_cnt+1, modulo 2^16.
- Clock edge without a grant: cdb_valid<=0; cdb_tag, cdb_data, cdb_src, ptr and bcast_cnt hold.
- flush=1 forces cdb_valid<=0 at the next edge and blocks any grant in that cycle. ptr and bcast_cnt are unchanged.
- Requester contract:
  - Hold req, tag and data stable until the cycle in which grant[i]=1 is seen.
  - Deassert req, or present the next result, on the following cycle.
  - The arbiter does not check this contract.
- Reset values: ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, bcast_cnt=0, grant=0.
  - grant is 0 while rst_n=0, regardless of req.
- Reset mid-operation: a grant issued in the reset cycle is discarded, and nothing is broadcast afterwards.

## Timing
- Request to grant: 0 cycles. The combinational path is req/ptr/cdb_ready/flush -> grant.
- Grant to broadcast: 1 cycle. cdb_valid is high for exactly one cycle per grant.
- Throughput: one broadcast per cycle. Back-to-back grants produce cdb_valid high continuously, with cdb_src changing each cycle.
- Fairness: a continuously requesting input waits at most NREQ-1 grant cycles.
- cdb_ready low: no grant. Requesters stall, and cdb_valid drops on the next edge.
- flush and cdb_ready both high: flush wins, and no grant is issued.
- Exactly one requester: it is granted every cycle it requests, regardless of ptr.

## Test plan
- Reset, then idle with req=0: grant=0, cdb_valid=0, and all registered outputs 0 for 10 cycles.
- Single request: req=6'b000010, tag 5, data 0x1234 -> grant=000010 that cycle. The next cycle shows cdb_valid=1, cdb_tag=5, cdb_data=0x1234, cdb_src=1; ptr becomes 2.
- All six requesting continuously from reset: the grant order is 0,1,2,3,4,5,0. After 7 cycles bcast_cnt=7, cdb_valid is high for cycles 1–7, and the wrap from 5 to 0 is observed.
- Hold-off on busy ROB: with ptr=3, requesters 1 and 4 request.
  - With cdb_ready=0 for 3 cycles: no grant, and cdb_valid=0.
  - Once cdb_ready returns to 1: grant 4 first, then 1.
- flush asserted while requester 2 requests: grant=0 and cdb_valid=0 next cycle, with ptr and bcast_cnt unchanged. The cycle after flush drops, requester 2 is granted.
- Counter wrap and reset mid-operation:
  - Preload the count via 65535 broadcasts; one more grant gives bcast_cnt=0.
  - rst_n=0 in a cycle with a grant: the next cycle shows cdb_valid=0, ptr=0 and bcast_cnt=0.
